// File: rtl/snn_layer_manager.sv
// Layer controller: per-layer config/weights, spike integrate-and-fire.
// Ports: AXI-S spikes in/out, config/weight write, layer select, counters.
module snn_layer_manager #(
  parameter int MAX_LAYERS   = 16,
  parameter int DATA_WIDTH   = 48,
  parameter int CONFIG_WIDTH = 32,
  parameter int WEIGHT_WIDTH = 8,
  parameter int VMEM_WIDTH   = 16,
  parameter int NUM_NEURONS  = 64,
  parameter int VTH          = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [DATA_WIDTH-1:0]   s_axis_input_tdata,
  input  logic                    s_axis_input_tvalid,
  output logic                    s_axis_input_tready,
  input  logic                    s_axis_input_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_output_tdata,
  output logic                    m_axis_output_tvalid,
  input  logic                    m_axis_output_tready,
  output logic                    m_axis_output_tlast,
  input  logic [7:0]              config_layer_id,
  input  logic [7:0]              config_layer_type,
  input  logic [CONFIG_WIDTH-1:0] config_data,
  input  logic                    config_write,
  input  logic [7:0]              weight_layer_id,
  input  logic [15:0]             weight_addr,
  input  logic [WEIGHT_WIDTH-1:0] weight_data,
  input  logic                    weight_write,
  input  logic [7:0]              execute_layer_id,
  input  logic                    execute_start,
  output logic                    execute_done,
  output logic [31:0]             total_input_spikes,
  output logic [31:0]             total_output_spikes,
  output logic [MAX_LAYERS-1:0]   layer_active_status,
  output logic [7:0]              current_layer_id
);

  localparam int LW = $clog2(MAX_LAYERS);
  localparam int IW = $clog2(NUM_NEURONS);
  localparam int SW = VMEM_WIDTH + 1;
  localparam logic [7:0] MAX_ID = 8'(MAX_LAYERS);
  localparam logic [15:0] MAX_ADDR = 16'(NUM_NEURONS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_NEURONS - 1);
  localparam logic signed [VMEM_WIDTH-1:0] VTH_V = VMEM_WIDTH'(VTH);
  localparam logic signed [VMEM_WIDTH-1:0] VMAX =
    {1'b0, {(VMEM_WIDTH-1){1'b1}}};
  localparam logic signed [VMEM_WIDTH-1:0] VMIN =
    {1'b1, {(VMEM_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT,
    CLEAR
  } state_t;

  state_t state;

  logic [7:0]              layer_type  [MAX_LAYERS];
  logic [CONFIG_WIDTH-1:0] layer_param [MAX_LAYERS];
  logic [MAX_LAYERS-1:0]   layer_en;

  logic signed [WEIGHT_WIDTH-1:0] wram [MAX_LAYERS][NUM_NEURONS];
  logic signed [VMEM_WIDTH-1:0]   vmem [NUM_NEURONS];

  logic [DATA_WIDTH-1:0] in_word;
  logic                  in_last;
  logic [IW-1:0]         clr_idx;

  logic [LW-1:0] cfg_sel;
  logic [LW-1:0] wr_sel;
  logic [LW-1:0] cur_sel;
  logic [IW-1:0] in_idx;
  logic [7:0]    in_amp;
  logic          cur_ok;

  logic signed [SW-1:0]         acc_sum;
  logic signed [VMEM_WIDTH-1:0] acc_sat;

  logic unused_sink;

  assign cfg_sel = config_layer_id[LW-1:0];
  assign wr_sel  = weight_layer_id[LW-1:0];
  assign cur_sel = current_layer_id[LW-1:0];
  assign in_idx  = in_word[8 +: IW];
  assign in_amp  = in_word[7:0];

  // Out-of-range selections behave as a disabled layer.
  assign cur_ok = (current_layer_id < MAX_ID) && layer_en[cur_sel];

  assign layer_active_status = layer_en;

  // A pending start wins over a same-cycle spike.
  assign s_axis_input_tready = (state == IDLE) && enable &&
                               !m_axis_output_tvalid && !execute_start;

  always_comb begin
    acc_sum = {vmem[in_idx][VMEM_WIDTH-1], vmem[in_idx]} +
              SW'(wram[cur_sel][in_idx]);
    acc_sat = acc_sum[VMEM_WIDTH-1:0];
    if (acc_sum[SW-1] != acc_sum[SW-2])
      acc_sat = acc_sum[SW-1] ? VMIN : VMAX;
  end

  always_comb begin
    unused_sink = ^{config_layer_type, in_word[15:14]};
    for (int i = 0; i < MAX_LAYERS; i++)
      unused_sink = unused_sink ^ (^{layer_type[i], layer_param[i]});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      layer_en <= '0;
      for (int i = 0; i < MAX_LAYERS; i++) begin
        layer_type[i]  <= '0;
        layer_param[i] <= '0;
      end
    end else if (config_write && (config_layer_id < MAX_ID)) begin
      if (config_data[CONFIG_WIDTH-1 -: 8] == 8'hFF) begin
        layer_type[cfg_sel] <= config_data[7:0];
        layer_en[cfg_sel]   <= |config_data[7:0];
      end else begin
        layer_param[cfg_sel] <= config_data;
      end
    end
  end

  // Weight RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (weight_write && (weight_layer_id < MAX_ID) &&
        (weight_addr < MAX_ADDR))
      wram[wr_sel][weight_addr[IW-1:0]] <= weight_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      current_layer_id     <= '0;
      execute_done         <= 1'b0;
      m_axis_output_tvalid <= 1'b0;
      m_axis_output_tdata  <= '0;
      m_axis_output_tlast  <= 1'b0;
      total_input_spikes   <= '0;
      total_output_spikes  <= '0;
      in_word              <= '0;
      in_last              <= 1'b0;
      clr_idx              <= '0;
      for (int i = 0; i < NUM_NEURONS; i++)
        vmem[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (execute_start) begin
            current_layer_id <= execute_layer_id;
            execute_done     <= 1'b0;
            clr_idx          <= '0;
            state            <= CLEAR;
          end else if (s_axis_input_tvalid && s_axis_input_tready) begin
            in_word            <= s_axis_input_tdata;
            in_last            <= s_axis_input_tlast;
            total_input_spikes <= total_input_spikes + 32'd1;
            state              <= ACCUM;
          end
        end
        ACCUM: begin
          state <= IDLE;
          if (cur_ok && (in_amp != 8'd0)) begin
            if (acc_sat >= VTH_V) begin
              vmem[in_idx]        <= '0;
              m_axis_output_tdata <= {in_word[DATA_WIDTH-1:16], 2'b00,
                                      in_word[13:8], current_layer_id};
              m_axis_output_tlast <= in_last;
              state               <= EMIT;
            end else begin
              vmem[in_idx] <= acc_sat;
            end
          end
        end
        EMIT: begin
          if (!m_axis_output_tvalid) begin
            m_axis_output_tvalid <= 1'b1;
          end else if (m_axis_output_tready) begin
            m_axis_output_tvalid <= 1'b0;
            total_output_spikes  <= total_output_spikes + 32'd1;
            state                <= IDLE;
          end
        end
        CLEAR: begin
          vmem[clr_idx] <= '0;
          clr_idx       <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            execute_done <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_layer_manager.sv
// Self-checking bench for snn_layer_manager.
// Config table, scoreboarded spike sequences, clear and back-pressure.
module tb_snn_layer_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [47:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [47:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [7:0]  cfg_id;
  logic [7:0]  cfg_type;
  logic [31:0] cfg_data;
  logic        cfg_wr;
  logic [7:0]  w_layer;
  logic [15:0] w_addr;
  logic [7:0]  w_data;
  logic        w_wr;
  logic [7:0]  ex_id;
  logic        ex_start;
  logic        ex_done;
  logic [31:0] in_cnt;
  logic [31:0] out_cnt;
  logic [15:0] status;
  logic [7:0]  cur_id;

  always #5 clk = ~clk;

  snn_layer_manager dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .s_axis_input_tdata   (s_tdata),
    .s_axis_input_tvalid  (s_tvalid),
    .s_axis_input_tready  (s_tready),
    .s_axis_input_tlast   (s_tlast),
    .m_axis_output_tdata  (m_tdata),
    .m_axis_output_tvalid (m_tvalid),
    .m_axis_output_tready (m_tready),
    .m_axis_output_tlast  (m_tlast),
    .config_layer_id      (cfg_id),
    .config_layer_type    (cfg_type),
    .config_data          (cfg_data),
    .config_write         (cfg_wr),
    .weight_layer_id      (w_layer),
    .weight_addr          (w_addr),
    .weight_data          (w_data),
    .weight_write         (w_wr),
    .execute_layer_id     (ex_id),
    .execute_start        (ex_start),
    .execute_done         (ex_done),
    .total_input_spikes   (in_cnt),
    .total_output_spikes  (out_cnt),
    .layer_active_status  (status),
    .current_layer_id     (cur_id)
  );

  typedef struct {
    logic [47:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [15:0] status;
  } cfg_vec_t;

  exp_t     sb[$];
  exp_t     got;
  cfg_vec_t cv[8];
  int       passed = 0;
  int       total  = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  always @(negedge clk) begin
    if (!reset && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", m_tdata, 48'h0);
      end else begin
        got = sb.pop_front();
        chk("out_tdata", m_tdata, got.data);
        chk("out_tlast", m_tlast, got.last);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    enable   = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    cfg_id   = '0;
    cfg_type = '0;
    cfg_data = '0;
    cfg_wr   = 1'b0;
    w_layer  = '0;
    w_addr   = '0;
    w_data   = '0;
    w_wr     = 1'b0;
    ex_id    = '0;
    ex_start = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic cfg(input logic [7:0] id, input logic [31:0] d);
    cfg_id   = id;
    cfg_data = d;
    cfg_wr   = 1'b1;
    tick();
    cfg_wr   = 1'b0;
  endtask

  task automatic wr(input logic [7:0] l, input logic [15:0] a,
                    input logic [7:0] d);
    w_layer = l;
    w_addr  = a;
    w_data  = d;
    w_wr    = 1'b1;
    tick();
    w_wr    = 1'b0;
  endtask

  task automatic send(input logic [31:0] tag, input logic [5:0] idx,
                      input logic [7:0] amp, input logic last,
                      input logic fire, input logic [7:0] lid);
    exp_t e;
    bit   ok = 0;
    s_tdata  = {tag, 2'b00, idx, amp};
    s_tlast  = last;
    s_tvalid = 1'b1;
    if (fire) begin
      e.data = {tag, 2'b00, idx, lid};
      e.last = last;
      sb.push_back(e);
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic settle;
    repeat (6) tick();
    chk("sb_drained", 64'(sb.size()), 0);
  endtask

  task automatic select(input logic [7:0] id, output int n);
    ex_id    = id;
    ex_start = 1'b1;
    tick();
    ex_start = 1'b0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_tready) break;
      n++;
    end
    tick();
  endtask

  int          ncyc;
  bit          stable;
  logic [47:0] held;

  initial begin
    cv[0] = '{8'd0,  32'hFF000001, 16'h0001};
    cv[1] = '{8'd1,  32'hFF000002, 16'h0003};
    cv[2] = '{8'd2,  32'hFF000004, 16'h0007};
    cv[3] = '{8'd1,  32'h12345678, 16'h0007};
    cv[4] = '{8'd2,  32'h00000000, 16'h0007};
    cv[5] = '{8'd20, 32'hFF000001, 16'h0007};
    cv[6] = '{8'd2,  32'hFF000000, 16'h0003};
    cv[7] = '{8'd15, 32'hFF000010, 16'h8003};

    do_reset();
    chk("rst_status", status, 0);
    chk("rst_in_cnt", in_cnt, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_cur_id", cur_id, 0);
    chk("rst_done", ex_done, 0);
    chk("rst_tvalid", m_tvalid, 0);
    enable = 1'b1;
    #1;
    chk("rst_tready", s_tready, 1);

    for (int i = 0; i < 10; i++)
      send(32'h1000 + i, 6'd3, 8'd1, 1'b0, 1'b0, 8'd0);
    settle();
    chk("uncfg_in_cnt", in_cnt, 10);
    chk("uncfg_out_cnt", out_cnt, 0);

    for (int i = 0; i < 8; i++) begin
      cfg(cv[i].id, cv[i].data);
      chk($sformatf("cfg_status_%0d", i), status, cv[i].status);
    end

    do_reset();
    enable = 1'b1;
    cfg(8'd0, 32'hFF000004);
    chk("l0_status", status, 16'h0001);
    for (int i = 0; i < 16; i++)
      wr(8'd0, 16'(i), 8'(10 * i));
    wr(8'd0, 16'd67, 8'd100);
    send(32'hABCD1234, 6'd3, 8'd1, 1'b0, 1'b0, 8'd0);
    send(32'hABCD1234, 6'd3, 8'd1, 1'b0, 1'b0, 8'd0);
    send(32'hABCD1234, 6'd3, 8'd1, 1'b1, 1'b1, 8'd0);
    settle();
    chk("fire_in_cnt", in_cnt, 3);
    chk("fire_out_cnt", out_cnt, 1);

    send(32'h2, 6'd3, 8'd0, 1'b0, 1'b0, 8'd0);
    send(32'h2, 6'd3, 8'd0, 1'b0, 1'b0, 8'd0);
    send(32'h3, 6'd3, 8'd1, 1'b0, 1'b0, 8'd0);
    settle();
    chk("amp0_out_cnt", out_cnt, 1);

    select(8'd0, ncyc);
    chk("clear_cycles", 64'(ncyc), 64);
    chk("clear_done", ex_done, 1);
    chk("clear_cur_id", cur_id, 0);
    send(32'h4, 6'd3, 8'd1, 1'b0, 1'b0, 8'd0);
    send(32'h4, 6'd3, 8'd1, 1'b0, 1'b0, 8'd0);
    send(32'hBEEF, 6'd3, 8'd1, 1'b1, 1'b1, 8'd0);
    settle();
    chk("clear_in_cnt", in_cnt, 9);
    chk("clear_out_cnt", out_cnt, 2);

    select(8'd20, ncyc);
    chk("sel20_cur_id", cur_id, 20);
    send(32'h5, 6'd3, 8'd1, 1'b0, 1'b0, 8'd20);
    settle();
    chk("sel20_in_cnt", in_cnt, 10);
    chk("sel20_out_cnt", out_cnt, 2);

    do_reset();
    enable = 1'b1;
    cfg(8'd0, 32'hFF000004);
    wr(8'd0, 16'd7, 8'd70);
    m_tready = 1'b0;
    send(32'h5A5A0007, 6'd7, 8'd1, 1'b1, 1'b1, 8'd0);
    for (int k = 0; k < 20 && !m_tvalid; k++) tick();
    chk("bp_tvalid", m_tvalid, 1);
    held   = m_tdata;
    stable = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!m_tvalid || m_tdata !== held || s_tready) stable = 0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_held_idx", held[15:8], 8'd7);
    chk("bp_out_cnt_hold", out_cnt, 0);
    m_tready = 1'b1;
    repeat (3) tick();
    chk("bp_out_cnt", out_cnt, 1);
    chk("bp_in_cnt", in_cnt, 1);
    chk("bp_tvalid_low", m_tvalid, 0);
    settle();

    enable = 1'b0;
    #1;
    chk("en_off_tready", s_tready, 0);
    enable = 1'b1;
    #1;
    chk("en_on_tready", s_tready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
